// File: rtl/frame_word_packer_pkg.sv
// Shared types and constants for the frame word packer.
package frame_word_packer_pkg;
  typedef enum logic [1:0] {ST_SYNC = 2'd0, ST_BLANK = 2'd1, ST_ACTIVE = 2'd2} state_e;
  localparam int PIX_PER_WORD = 4;
  localparam int PIX_W        = 8;
  localparam int WORD_W       = 32;
  localparam int LANE_W       = 2;
endpackage

// File: rtl/frame_word_packer_fifo.sv
// Small synchronous FIFO; a push while full is only taken if a pop frees a slot that cycle.
module pixel_word_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  logic          do_pop, do_push;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/frame_word_packer.sv
// Packs a blanking-delimited 8-bit pixel stream into addressed 32-bit words behind a small FIFO.
module frame_word_packer
  import frame_word_packer_pkg::*;
#(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [PIX_W-1:0]  data,
  input  logic              blankingregion,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic [ADDR_W-1:0] word_addr,
  output logic              word_last,
  output logic              frame_start,
  output logic              frame_done,
  output logic              frame_error,
  output logic              overflow
);
  localparam int WORDS = WIDTH * HEIGHT / PIX_PER_WORD;
  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT + 1);
  localparam int FW    = WORD_W + ADDR_W + 1;

  state_e              state_q;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [LANE_W-1:0]   lane_q;
  logic [WORD_W-1:0]   pack_q, pack_ins, push_word;
  logic [ADDR_W-1:0]   word_q;
  logic                fs_q, fd_q, err_q, ovf_q;
  logic                pix, blk, frame_full, acc, push, push_last, fifo_full, fifo_empty;

  assign pix        = valid & ~blankingregion;
  assign blk        = valid & blankingregion;
  // y reaching HEIGHT means every active pixel of the frame has arrived
  assign frame_full = (y_q == YW'(HEIGHT));
  assign acc        = (state_q == ST_ACTIVE) & pix & ~frame_full;

  always_comb begin
    pack_ins = pack_q;
    pack_ins[PIX_W*lane_q +: PIX_W] = data;
  end

  always_comb begin
    push      = 1'b0;
    push_word = pack_ins;
    push_last = (word_q == ADDR_W'(WORDS - 1));
    if (acc && lane_q == LANE_W'(PIX_PER_WORD - 1)) begin
      push = 1'b1;
    end else if (state_q == ST_ACTIVE && blk && lane_q != '0) begin
      push      = 1'b1;
      push_word = pack_q;
      push_last = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SYNC;
      x_q     <= '0;
      y_q     <= '0;
      lane_q  <= '0;
      pack_q  <= '0;
      word_q  <= '0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      fd_q <= 1'b0;
      if (push && fifo_full && !word_ready) ovf_q <= 1'b1;
      case (state_q)
        ST_SYNC: if (blk) state_q <= ST_BLANK;
        ST_BLANK: if (pix) begin
          state_q <= ST_ACTIVE;
          fs_q    <= 1'b1;
          pack_q  <= {{(WORD_W-PIX_W){1'b0}}, data};
          lane_q  <= LANE_W'(1);
          x_q     <= XW'(1);
          y_q     <= '0;
          word_q  <= '0;
        end
        ST_ACTIVE: if (blk) begin
          state_q <= ST_BLANK;
          fd_q    <= 1'b1;
          if (!frame_full) err_q <= 1'b1;
          lane_q  <= '0;
          pack_q  <= '0;
          x_q     <= '0;
          y_q     <= '0;
          word_q  <= '0;
        end else if (pix) begin
          if (frame_full) begin
            err_q <= 1'b1;
          end else begin
            lane_q <= lane_q + 1'b1;
            if (lane_q == LANE_W'(PIX_PER_WORD - 1)) begin
              pack_q <= '0;
              word_q <= word_q + 1'b1;
            end else begin
              pack_q <= pack_ins;
            end
            if (x_q == XW'(WIDTH - 1)) begin
              x_q <= '0;
              y_q <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_SYNC;
      endcase
    end
  end

  pixel_word_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({push_last, word_q, push_word}),
    .pop_i       (word_ready),
    .head_o      ({word_last, word_addr, word_data}),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign word_valid  = ~fifo_empty;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign frame_error = err_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_frame_word_packer.sv
// Directed tables plus randomized frames checked against a pixel-count based reference model.
module tb_frame_word_packer;
  localparam int WIDTH = 8, HEIGHT = 2, ADDR_W = 2, DEPTH = 4;
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int WORDS = TOTAL / 4;

  logic clock = 1'b0, reset = 1'b0;
  logic valid = 1'b0, blankingregion = 1'b0, word_ready = 1'b0;
  logic [7:0] data = '0;
  logic word_valid, word_last, frame_start, frame_done, frame_error, overflow;
  logic [31:0] word_data;
  logic [ADDR_W-1:0] word_addr;

  int checks = 0, errors = 0, fs_cnt = 0;

  typedef struct {logic [31:0] d; int a; logic l;} w_t;
  w_t pops[$];
  w_t mq[$];
  int m_mode = 0, m_n = 0;
  logic [31:0] m_part = '0;
  logic m_fs = 0, m_fd = 0, m_err = 0, m_ovf = 0;

  typedef struct {logic v, b; logic [7:0] d; logic wv; logic [31:0] wd; int wa; logic wl, fs, fd;} vec_t;
  vec_t tbl[18];

  frame_word_packer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .valid(valid), .data(data), .blankingregion(blankingregion),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data), .word_addr(word_addr),
    .word_last(word_last), .frame_start(frame_start), .frame_done(frame_done),
    .frame_error(frame_error), .overflow(overflow));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s got %0h want %0h @%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of pixels; every 4th pixel completes a word.
  task automatic model_step();
    logic pop, pushed;
    w_t w;
    pushed = 1'b0;
    w = '{d: 32'h0, a: 0, l: 1'b0};
    pop = word_ready && (mq.size() != 0);
    m_fs = 1'b0;
    m_fd = 1'b0;
    if (valid && blankingregion) begin
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 2) begin
        m_mode = 1;
        m_fd = 1'b1;
        if (m_n != TOTAL) m_err = 1'b1;
        if (m_n % 4 != 0) begin
          w = '{d: m_part, a: m_n / 4, l: 1'b1};
          pushed = 1'b1;
        end
        m_part = '0;
        m_n = 0;
      end
    end else if (valid) begin
      if (m_mode == 1) begin
        m_mode = 2;
        m_fs = 1'b1;
        m_n = 0;
        m_part = '0;
      end
      if (m_mode == 2) begin
        if (m_n == TOTAL) m_err = 1'b1;
        else begin
          m_part[8*(m_n%4) +: 8] = data;
          m_n++;
          if (m_n % 4 == 0) begin
            w = '{d: m_part, a: m_n / 4 - 1, l: (m_n / 4 == WORDS)};
            pushed = 1'b1;
            m_part = '0;
          end
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (pushed) begin
      if (mq.size() < DEPTH) mq.push_back(w);
      else m_ovf = 1'b1;
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      mq.delete();
      m_mode = 0; m_n = 0; m_part = '0;
      m_fs = 0; m_fd = 0; m_err = 0; m_ovf = 0;
    end
    chk("m_wvalid", word_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("m_data", word_data, mq[0].d);
      chk("m_addr", word_addr, mq[0].a);
      chk("m_last", word_last, mq[0].l);
    end
    chk("m_fstart", frame_start, m_fs);
    chk("m_fdone", frame_done, m_fd);
    chk("m_ferr", frame_error, m_err);
    chk("m_ovf", overflow, m_ovf);
    if (frame_start) fs_cnt++;
    if (word_valid && word_ready) pops.push_back('{d: word_data, a: int'(word_addr), l: word_last});
    if (reset) model_step();
  end

  task automatic drive(input logic v, input logic b, input logic [7:0] d);
    valid = v; blankingregion = b; data = d;
    @(posedge clock); #1;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    pops.delete();
    fs_cnt = 0;
  endtask

  task automatic ramp(input int first, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'(first + i));
  endtask

  task automatic chk_pop(input string name, input int idx, input logic [31:0] d, input int a, input logic l);
    if (pops.size() <= idx) chk({name, "_missing"}, pops.size(), idx + 1);
    else begin
      chk({name, "_d"}, pops[idx].d, d);
      chk({name, "_a"}, pops[idx].a, a);
      chk({name, "_l"}, pops[idx].l, l);
    end
  endtask

  initial begin
    tbl[0] = '{v: 1, b: 1, d: 0, wv: 0, wd: 0, wa: 0, wl: 0, fs: 0, fd: 0};
    for (int i = 0; i < 16; i++) begin
      tbl[i+1].v = 1'b1; tbl[i+1].b = 1'b0; tbl[i+1].d = 8'(i);
      tbl[i+1].wv = (i % 4 == 3);
      tbl[i+1].wd = {8'(i), 8'(i-1), 8'(i-2), 8'(i-3)};
      tbl[i+1].wa = i / 4;
      tbl[i+1].wl = (i == 15);
      tbl[i+1].fs = (i == 0);
      tbl[i+1].fd = 1'b0;
    end
    tbl[17] = '{v: 1, b: 1, d: 0, wv: 0, wd: 0, wa: 0, wl: 0, fs: 0, fd: 1};

    idle(1);
    chk("rst_wvalid", word_valid, 0);
    chk("rst_flags", {frame_start, frame_done, frame_error, overflow}, 0);
    reset = 1'b1;
    idle(1);

    // 1+2: pixels before blanking ignored, then a full ramp frame
    word_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'hAA);
    chk("sync_nopush", word_valid, 0);
    chk("sync_nostart", fs_cnt, 0);
    for (int r = 0; r < 18; r++) begin
      drive(tbl[r].v, tbl[r].b, tbl[r].d);
      chk($sformatf("tbl%0d_wv", r), word_valid, tbl[r].wv);
      if (tbl[r].wv) begin
        chk($sformatf("tbl%0d_wd", r), word_data, tbl[r].wd);
        chk($sformatf("tbl%0d_wa", r), word_addr, tbl[r].wa);
        chk($sformatf("tbl%0d_wl", r), word_last, tbl[r].wl);
      end
      chk($sformatf("tbl%0d_fs", r), frame_start, tbl[r].fs);
      chk($sformatf("tbl%0d_fd", r), frame_done, tbl[r].fd);
    end
    chk("t2_start_once", fs_cnt, 1);
    chk("t2_ferr", frame_error, 0);

    // 3: stalled consumer, fifth word dropped, then drain in order
    do_reset();
    drive(1'b1, 1'b1, 8'h0);
    word_ready = 1'b0;
    ramp(0, 16);
    drive(1'b1, 1'b1, 8'h0);
    ramp(16, 4);
    chk("t3_ovf", overflow, 1);
    chk("t3_hold_d", word_data, 32'h03020100);
    word_ready = 1'b1;
    idle(6);
    chk("t3_npops", pops.size(), 4);
    for (int k = 0; k < 4; k++)
      chk_pop("t3_pop", k, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, k, k == 3);
    chk("t3_ferr", frame_error, 0);

    // 4: truncated frame flushes a partial word
    do_reset();
    word_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h0);
    ramp(0, 6);
    drive(1'b1, 1'b1, 8'h0);
    chk("t4_fdone", frame_done, 1);
    chk("t4_ferr", frame_error, 1);
    ramp(8'h10, 4);
    idle(3);
    chk("t4_npops", pops.size(), 3);
    chk_pop("t4_w0", 0, 32'h03020100, 0, 0);
    chk_pop("t4_w1", 1, 32'h00000504, 1, 1);
    chk_pop("t4_w2", 2, 32'h13121110, 0, 0);

    // 5: push and pop together while full
    do_reset();
    drive(1'b1, 1'b1, 8'h0);
    word_ready = 1'b0;
    ramp(0, 16);
    drive(1'b1, 1'b1, 8'h0);
    ramp(8'h20, 3);
    word_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h23);
    chk("t5_ovf", overflow, 0);
    idle(6);
    chk("t5_npops", pops.size(), 5);
    chk_pop("t5_first", 0, 32'h03020100, 0, 0);
    chk_pop("t5_new", 4, 32'h23222120, 0, 0);

    // 6: reset mid-line clears everything and re-syncs on blanking
    do_reset();
    word_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h0);
    ramp(0, 6);
    drive(1'b1, 1'b1, 8'h0);
    ramp(0, 2);
    chk("t6_pre_err", frame_error, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_out", {word_valid, word_data, word_addr, word_last, frame_start, frame_done, frame_error, overflow}, 0);
    idle(1);
    reset = 1'b1;
    pops.delete();
    fs_cnt = 0;
    word_ready = 1'b1;
    ramp(8'h40, 3);
    idle(2);
    chk("t6_ignored", pops.size(), 0);
    chk("t6_nostart", fs_cnt, 0);
    drive(1'b1, 1'b1, 8'h0);
    ramp(8'h50, 4);
    idle(2);
    chk("t6_npops", pops.size(), 1);
    chk_pop("t6_w", 0, 32'h53525150, 0, 0);

    // random frames of varying length with random stalls and bubbles
    do_reset();
    for (int f = 0; f < 150; f++) begin
      int len;
      len = ($urandom_range(0, 1) != 0) ? TOTAL : $urandom_range(0, TOTAL + 4);
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
        word_ready = ($urandom_range(0, 9) < 7);
        drive(1'b1, 1'b1, 8'($urandom));
      end
      for (int p = 0; p < len; p++) begin
        while ($urandom_range(0, 4) == 0) begin
          word_ready = ($urandom_range(0, 9) < 7);
          drive(1'b0, 1'($urandom), 8'($urandom));
        end
        word_ready = ($urandom_range(0, 9) < 7);
        drive(1'b1, 1'b0, 8'($urandom));
      end
    end
    word_ready = 1'b1;
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
